// File: rtl/uart_rxer.sv
// rtl/uart_rxer.sv - 8N1 UART receiver with glitch rejection and framing-error/break handling
`timescale 1ns/1ps
module uart_rxer #(
    parameter int BAUD_DIV = 5000,
    parameter int CNT_W    = 13
) (
    input  logic       clk,
    input  logic       res,
    input  logic       RX,
    output logic [7:0] data_out,
    output logic       en_data_out,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(BAUD_DIV - 1);

    logic             r_rx_m;
    logic             r_rx_s;
    logic             r_rx_d;
    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_data_out;
    logic             r_en_data_out;
    logic             r_frame_err;

    // Edge flop resets low, so a line already low at reset release cannot start a frame.
    logic w_start_edge;
    assign w_start_edge = r_rx_d & ~r_rx_s;

    always_ff @(posedge clk) begin
        if (!res) begin
            r_rx_m        <= 1'b0;
            r_rx_s        <= 1'b0;
            r_rx_d        <= 1'b0;
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_idx         <= 3'd0;
            r_shift       <= 8'h00;
            r_data_out    <= 8'h00;
            r_en_data_out <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_rx_m        <= RX;
            r_rx_s        <= r_rx_m;
            r_rx_d        <= r_rx_s;
            r_en_data_out <= 1'b0;
            r_frame_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start_edge) begin
                        r_state <= S_START;
                        r_cnt   <= '0;
                    end
                end
                S_START: begin
                    if (r_cnt == HALF_M1) begin
                        r_cnt <= '0;
                        if (!r_rx_s) begin
                            r_state <= S_DATA;
                            r_idx   <= 3'd0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (r_cnt == FULL_M1) begin
                        r_cnt   <= '0;
                        r_shift <= {r_rx_s, r_shift[7:1]};
                        if (r_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    // Leaving at mid-stop lets a back-to-back start edge be caught.
                    if (r_cnt == FULL_M1) begin
                        r_cnt <= '0;
                        if (r_rx_s) begin
                            r_data_out    <= r_shift;
                            r_en_data_out <= 1'b1;
                            r_state       <= S_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_BREAK: begin
                    if (r_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign data_out    = r_data_out;
    assign en_data_out = r_en_data_out;
    assign frame_err   = r_frame_err;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rxer.sv
// tb/tb_uart_rxer.sv - directed self-checking bench for uart_rxer at BAUD_DIV=16
`timescale 1ns/1ps
module tb_uart_rxer;

    logic       clk = 1'b0;
    logic       res = 1'b0;
    logic       RX  = 1'b1;
    logic [7:0] data_out;
    logic       en_data_out;
    logic       frame_err;
    logic       busy;

    uart_rxer #(.BAUD_DIV(16), .CNT_W(5)) dut (
        .clk         (clk),
        .res         (res),
        .RX          (RX),
        .data_out    (data_out),
        .en_data_out (en_data_out),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    // Event log sampled on the falling edge, stamped with the rising-edge count.
    bit         mon_en = 1'b0;
    logic       prev_busy = 1'b0;
    int         en_cyc[$];
    logic [7:0] en_dat[$];
    int         fe_cyc[$];
    int         brise[$];
    int         bfall[$];

    always @(negedge clk) begin
        if (mon_en) begin
            if (en_data_out === 1'b1) begin
                en_cyc.push_back(cyc);
                en_dat.push_back(data_out);
            end
            if (frame_err === 1'b1) fe_cyc.push_back(cyc);
            if (busy === 1'b1 && prev_busy !== 1'b1) brise.push_back(cyc);
            if (busy !== 1'b1 && prev_busy === 1'b1) bfall.push_back(cyc);
            prev_busy = busy;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        en_cyc.delete();
        en_dat.delete();
        fe_cyc.delete();
        brise.delete();
        bfall.delete();
    endtask

    task automatic send_bit(input logic b);
        RX = b;
        repeat (16) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, output int c);
        c = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    // Falling edge driven after edge c, so t0 = c+1: busy rises c+3, pulse/idle at c+155.
    task automatic expect_frame(input string tag, input int c, input logic [7:0] d);
        check({tag, ".n_en"}, en_cyc.size(), 1);
        check({tag, ".en_cyc"}, en_cyc[0], c + 155);
        check({tag, ".en_dat"}, en_dat[0], d);
        check({tag, ".data_out"}, data_out, d);
        check({tag, ".n_fe"}, fe_cyc.size(), 0);
        check({tag, ".busy_rise"}, brise[0], c + 3);
        check({tag, ".busy_fall"}, bfall[0], c + 155);
    endtask

    initial begin
        int c;
        int c2;

        res = 1'b0;
        RX  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst.data_out", data_out, 8'h00);
        check("rst.en", en_data_out, 1'b0);
        check("rst.fe", frame_err, 1'b0);
        check("rst.busy", busy, 1'b0);
        res = 1'b1;
        mon_en = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        clear_log();
        send_frame(8'h0A, 1'b1, c);
        repeat (20) @(posedge clk);
        #1;
        expect_frame("single", c, 8'h0A);

        clear_log();
        send_frame(8'h55, 1'b1, c);
        send_frame(8'hA3, 1'b1, c2);
        repeat (20) @(posedge clk);
        #1;
        check("b2b.n_en", en_cyc.size(), 2);
        check("b2b.first_cyc", en_cyc[0], c + 155);
        check("b2b.gap", en_cyc[1] - en_cyc[0], 160);
        check("b2b.dat0", en_dat[0], 8'h55);
        check("b2b.dat1", en_dat[1], 8'hA3);
        check("b2b.n_fe", fe_cyc.size(), 0);

        clear_log();
        c = cyc;
        RX = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        RX = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("glitch.n_en", en_cyc.size(), 0);
        check("glitch.n_fe", fe_cyc.size(), 0);
        check("glitch.busy_rise", brise[0], c + 3);
        check("glitch.busy_fall", bfall[0], c + 11);
        clear_log();
        send_frame(8'h3C, 1'b1, c);
        repeat (20) @(posedge clk);
        #1;
        expect_frame("after_glitch", c, 8'h3C);

        clear_log();
        send_frame(8'hFF, 1'b0, c);
        repeat (48) @(posedge clk);
        #1;
        check("brk.busy_held", busy, 1'b1);
        RX = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("brk.n_fe", fe_cyc.size(), 1);
        check("brk.fe_cyc", fe_cyc[0], c + 155);
        check("brk.n_en", en_cyc.size(), 0);
        check("brk.data_kept", data_out, 8'h3C);
        check("brk.n_fall", bfall.size(), 1);
        check("brk.busy_fall", bfall[0], c + 211);
        clear_log();
        send_frame(8'h81, 1'b1, c);
        repeat (20) @(posedge clk);
        #1;
        expect_frame("after_brk", c, 8'h81);

        clear_log();
        RX = 1'b0;
        repeat (16 * 5 + 4) @(posedge clk);
        #1;
        res = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_rst.data_out", data_out, 8'h00);
        check("mid_rst.en", en_data_out, 1'b0);
        check("mid_rst.fe", frame_err, 1'b0);
        check("mid_rst.busy", busy, 1'b0);
        res = 1'b1;
        clear_log();
        repeat (200) @(posedge clk);
        #1;
        check("low_line.n_en", en_cyc.size(), 0);
        check("low_line.n_fe", fe_cyc.size(), 0);
        check("low_line.n_rise", brise.size(), 0);
        RX = 1'b1;
        repeat (32) @(posedge clk);
        #1;
        clear_log();
        send_frame(8'hC7, 1'b1, c);
        repeat (20) @(posedge clk);
        #1;
        expect_frame("after_rst", c, 8'hC7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rxer.md
# uart_rxer

Asynchronous serial receiver, 8N1, LSB first, idle-high line. It sits directly downstream of the UART transmitter: its RX input is the transmitter's TX line, after the board or testbench wiring. It recovers each byte by counting clocks to mid-bit, checks the stop bit, and hands the byte to the consumer as a one-cycle valid strobe. It also rejects start-bit glitches and flags framing errors.

## Interface
- BAUD_DIV, 5000: clocks per bit period. Minimum 4; must be even. Default matches the transmitter's bit period.
- CNT_W, 13: bit-period counter width; must satisfy 2^CNT_W > BAUD_DIV.

- clk  in  1  system clock, rising edge.
- res  in  1  reset, active-low, synchronous (sampled on rising clk only).
- RX  in  1  serial line, asynchronous to clk; idle high.
- data_out  out  8  last correctly framed byte; holds until the next good frame.
- en_data_out  out  1  one-clock pulse: data_out is valid and new this cycle.
- frame_err  out  1  one-clock pulse: stop bit sampled low.
- busy  out  1  high while a frame (or break) is in progress.

## Operation
- **Synchroniser:** two flops, rx_m then rx_s, plus an edge flop rx_d.
  - All three reset to 0.
  - A start edge is rx_d==1 && rx_s==0.
  - A line already low at reset release produces no start until it has been seen high.
- **States:** IDLE, START, DATA, STOP, BREAK. Bit counter cnt (CNT_W bits) and bit index idx (3 bits).
- **IDLE:** on start edge, go to START with cnt<=0.
- **START:** cnt increments each clk. At cnt==BAUD_DIV/2-1, cnt<=0 and rx_s is sampled:
  - 0 → go to DATA, idx<=0.
  - 1 → glitch; go to IDLE with no output.
- **DATA:** at cnt==BAUD_DIV-1, cnt<=0 and shift<={rx_s, shift[7:1]} (LSB first).
  - idx==7 → go to STOP; otherwise idx<=idx+1.
- **STOP:** at cnt==BAUD_DIV-1, rx_s is sampled:
  - 1 → data_out<=shift, en_data_out<=1, go to IDLE.
  - 0 → frame_err<=1, data_out unchanged, go to BREAK.
- **BREAK:** wait for rx_s==1, then go to IDLE. This is the only path out, so a line held low never re-triggers.
- **busy:** busy = (state != IDLE), registered with the state.
- **Pulses:** en_data_out and frame_err are each high for exactly one clock. They are never high in the same cycle.
- **Reset (res==0 at a clk edge):**
  - state=IDLE; cnt=0, idx=0, shift=0.
  - data_out=8'h00, en_data_out=0, frame_err=0, busy=0.
  - Synchroniser flops = 0.
  - Reset mid-frame aborts silently: no pulse, partial byte discarded.

## Timing
- t0 is the first clk edge at which rx_m captures RX low.
- START entered at edge t0+2 (busy high after t0+2).
- Start bit sampled at t0+2+BAUD_DIV/2.
- Data bit i (0..7) sampled at t0+2+BAUD_DIV/2+(i+1)·BAUD_DIV.
- Stop bit sampled at S = t0+2+BAUD_DIV/2+9·BAUD_DIV. Both the en_data_out/frame_err pulse and the return to IDLE (busy low) occur at edge S.
- IDLE is reached half a bit before the stop bit ends, so back-to-back frames with zero idle gap are received.
- A glitch shorter than BAUD_DIV/2 clocks returns to IDLE at edge t0+2+BAUD_DIV/2, with no output.
- Consumer has no backpressure. It must capture data_out on the en_data_out pulse; the next byte overwrites it no earlier than 10·BAUD_DIV clocks later.

## Test plan
All scenarios use BAUD_DIV=16, 10 ns clk, and a bench that drives RX with exact 16-clock bits.
- **Single frame:** frame 0x0A (bits 0,1,0,1,0,0,0,0), stop=1, falling edge before edge t0 → en_data_out one cycle at edge t0+154, data_out=0x0A, frame_err never high, busy high from t0+2 to t0+154.
- **Back-to-back:** 0x55 then 0xA3 with no idle gap → two en_data_out pulses exactly 160 clocks apart, data_out 0x55 then 0xA3.
- **Glitch rejection:** RX low for 4 clocks then high → busy high for edges t0+2..t0+10, no en_data_out, no frame_err; a following 0x3C frame is received correctly.
- **Framing error / break:** frame 0xFF with stop bit 0, line held low 3 more bit times → frame_err one cycle at the stop sample, data_out keeps its previous value (0x3C), busy stays high until RX returns high; the next frame 0x81 gives data_out=0x81.
- **Reset mid-frame:** res low for 3 clocks during data bit 4 → all outputs at reset values, no pulse. With RX held low through reset release, no start is detected until RX goes high then low; the next frame 0xC7 gives data_out=0xC7.
